// File: rtl/time_dmr_end.sv
// Receiving end of a time-redundant DMR link. It captures copy 0, compares it with copy 1 and
// forwards one element on a match. On a mismatch or a timeout it drops the element and asks for a retry.
`timescale 1ns/1ps
module time_dmr_end #(
    parameter type         DataType    = logic,
    parameter int unsigned IDSize      = 1,
    parameter int unsigned LockTimeout = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  DataType           data_i,
    input  logic [IDSize-1:0] id_i,
    input  logic              valid_i,
    output logic              ready_o,
    output DataType           data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              needs_retry_o,
    output logic [IDSize-1:0] retry_id_o,
    output logic              fault_detected_o
);

    localparam int unsigned CntW = (LockTimeout > 1) ? $clog2(LockTimeout) : 1;

    typedef enum logic [1:0] {StIdle, StWaitCopy1, StOutput} state_e;

    state_e            state_q, state_d;
    DataType           copy0_data_q, copy0_data_d;
    logic [IDSize-1:0] copy0_id_q, copy0_id_d;
    DataType           out_data_q, out_data_d;
    logic [IDSize-1:0] last_id_q, last_id_d;
    logic              last_id_valid_q, last_id_valid_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              retry_q, retry_d;
    logic [IDSize-1:0] retry_id_q, retry_id_d;
    logic              fault_q, fault_d;
    logic              in_ready;

    always_comb begin
        state_d         = state_q;
        copy0_data_d    = copy0_data_q;
        copy0_id_d      = copy0_id_q;
        out_data_d      = out_data_q;
        last_id_d       = last_id_q;
        last_id_valid_d = last_id_valid_q;
        cnt_d           = cnt_q;
        retry_d         = 1'b0;
        retry_id_d      = retry_id_q;
        fault_d         = 1'b0;
        in_ready        = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                // A copy carrying the ID that was just delivered is a leftover duplicate.
                if (valid_i && !(last_id_valid_q && (id_i == last_id_q))) begin
                    copy0_data_d = data_i;
                    copy0_id_d   = id_i;
                    cnt_d        = '0;
                    state_d      = StWaitCopy1;
                end
            end
            StWaitCopy1: begin
                in_ready = 1'b1;
                if (valid_i) begin
                    if (id_i == copy0_id_q) begin
                        if (data_i == copy0_data_q) begin
                            out_data_d      = data_i;
                            last_id_d       = id_i;
                            last_id_valid_d = 1'b1;
                            state_d         = StOutput;
                        end else begin
                            fault_d    = 1'b1;
                            retry_d    = 1'b1;
                            retry_id_d = id_i;
                            state_d    = StIdle;
                        end
                    end else begin
                        // The old element is lost. The new arrival becomes copy 0.
                        fault_d      = 1'b1;
                        retry_d      = 1'b1;
                        retry_id_d   = copy0_id_q;
                        copy0_data_d = data_i;
                        copy0_id_d   = id_i;
                        cnt_d        = '0;
                    end
                end else if (cnt_q == CntW'(LockTimeout - 1)) begin
                    fault_d    = 1'b1;
                    retry_d    = 1'b1;
                    retry_id_d = copy0_id_q;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StOutput: begin
                if (ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (!enable_i) begin
            state_d         = StIdle;
            cnt_d           = '0;
            last_id_valid_d = 1'b0;
            retry_d         = 1'b0;
            retry_id_d      = retry_id_q;
            fault_d         = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= StIdle;
            copy0_data_q    <= '0;
            copy0_id_q      <= '0;
            out_data_q      <= '0;
            last_id_q       <= '0;
            last_id_valid_q <= 1'b0;
            cnt_q           <= '0;
            retry_q         <= 1'b0;
            retry_id_q      <= '0;
            fault_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            copy0_data_q    <= copy0_data_d;
            copy0_id_q      <= copy0_id_d;
            out_data_q      <= out_data_d;
            last_id_q       <= last_id_d;
            last_id_valid_q <= last_id_valid_d;
            cnt_q           <= cnt_d;
            retry_q         <= retry_d;
            retry_id_q      <= retry_id_d;
            fault_q         <= fault_d;
        end
    end

    assign ready_o          = enable_i ? in_ready : ready_i;
    assign valid_o          = enable_i ? (state_q == StOutput) : valid_i;
    assign data_o           = enable_i ? out_data_q : data_i;
    assign needs_retry_o    = retry_q;
    assign retry_id_o       = retry_id_q;
    assign fault_detected_o = fault_q;

endmodule

// File: tb/tb_time_dmr_end.sv
// Scoreboard bench for time_dmr_end. The stimulus pushes the expected outputs and retry IDs.
// A negedge monitor pops these entries and compares them against what the DUT presents.
`timescale 1ns/1ps
module tb_time_dmr_end;

    typedef logic [7:0] data_t;
    localparam int unsigned IdW = 3;

    logic           clk = 1'b0;
    logic           rst_ni = 1'b0;
    logic           enable_i;
    data_t          data_i;
    logic [IdW-1:0] id_i;
    logic           valid_i;
    logic           ready_o;
    data_t          data_o;
    logic           valid_o;
    logic           ready_i;
    logic           needs_retry_o;
    logic [IdW-1:0] retry_id_o;
    logic           fault_detected_o;

    int n_checks = 0;
    int n_fail   = 0;

    data_t          exp_data_q[$];
    logic [IdW-1:0] exp_retry_q[$];

    time_dmr_end #(
        .DataType   (data_t),
        .IDSize     (IdW),
        .LockTimeout(4)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .enable_i        (enable_i),
        .data_i          (data_i),
        .id_i            (id_i),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .data_o          (data_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .needs_retry_o   (needs_retry_o),
        .retry_id_o      (retry_id_o),
        .fault_detected_o(fault_detected_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    task automatic send(input data_t d, input logic [IdW-1:0] id);
        data_i  = d;
        id_i    = id;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    // Monitor: one pop per output handshake or per retry pulse cycle.
    always @(negedge clk) begin
        if (rst_ni && enable_i) begin
            if (valid_o && ready_i) begin
                if (exp_data_q.size() == 0) flag("unexpected output");
                else check("out data", data_o, exp_data_q.pop_front());
            end
            if (needs_retry_o) begin
                if (exp_retry_q.size() == 0) flag("unexpected retry");
                else check("retry id", retry_id_o, exp_retry_q.pop_front());
            end
            if (needs_retry_o || fault_detected_o)
                check("fault with retry", fault_detected_o, needs_retry_o);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    data_t pt_data[4]  = '{8'h5A, 8'hC3, 8'hFF, 8'h00};
    logic  pt_valid[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic  pt_ready[4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        enable_i = 1'b1;
        data_i   = '0;
        id_i     = '0;
        valid_i  = 1'b0;
        ready_i  = 1'b1;
        @(posedge clk);
        #1;
        check("rst valid_o", valid_o, 0);
        check("rst data_o", data_o, 0);
        check("rst needs_retry", needs_retry_o, 0);
        check("rst retry_id", retry_id_o, 0);
        check("rst fault", fault_detected_o, 0);
        check("rst ready_o", ready_o, 1);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // 1: clean pair
        exp_data_q.push_back(8'hA5);
        send(8'hA5, 3'd3);
        check("t1 no early valid", valid_o, 0);
        send(8'hA5, 3'd3);
        check("t1 latency valid", valid_o, 1);
        check("t1 data", data_o, 8'hA5);
        check("t1 ready low", ready_o, 0);
        @(posedge clk);
        #1;
        check("t1 valid drops", valid_o, 0);

        // 2: data mismatch
        exp_retry_q.push_back(3'd1);
        send(8'h3C, 3'd1);
        send(8'h3D, 3'd1);
        check("t2 retry pulse", needs_retry_o, 1);
        check("t2 fault pulse", fault_detected_o, 1);
        check("t2 retry id", retry_id_o, 1);
        check("t2 no valid", valid_o, 0);
        @(posedge clk);
        #1;
        check("t2 pulse one cycle", needs_retry_o, 0);

        // 3: ID change drops the old element, and the new pair completes
        exp_retry_q.push_back(3'd2);
        exp_data_q.push_back(8'h22);
        send(8'h11, 3'd2);
        send(8'h22, 3'd5);
        check("t3 retry pulse", needs_retry_o, 1);
        send(8'h22, 3'd5);
        check("t3 valid", valid_o, 1);
        repeat (2) @(posedge clk);
        #1;

        // 4: lock timeout
        exp_retry_q.push_back(3'd0);
        send(8'h7E, 3'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("t4 no early timeout", needs_retry_o, 0);
        end
        @(posedge clk);
        #1;
        check("t4 timeout pulse", needs_retry_o, 1);
        check("t4 timeout fault", fault_detected_o, 1);
        check("t4 ready", ready_o, 1);
        @(posedge clk);
        #1;
        check("t4 idle no valid", valid_o, 0);

        // 5: backpressure, then a stray copy of the delivered ID
        ready_i = 1'b0;
        exp_data_q.push_back(8'h55);
        send(8'h55, 3'd4);
        send(8'h55, 3'd4);
        for (int i = 0; i < 6; i++) begin
            check("t5 valid held", valid_o, 1);
            check("t5 data held", data_o, 8'h55);
            check("t5 ready low", ready_o, 0);
            @(posedge clk);
            #1;
        end
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("t5 valid released", valid_o, 0);
        send(8'h55, 3'd4);
        repeat (6) @(posedge clk);
        #1;
        check("t5 stray ready", ready_o, 1);
        check("t5 stray no valid", valid_o, 0);

        // 6: pass-through, then reset in the middle of a pair
        enable_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_i  = pt_data[i];
            valid_i = pt_valid[i];
            ready_i = pt_ready[i];
            #1;
            check("t6 pt data", data_o, pt_data[i]);
            check("t6 pt valid", valid_o, pt_valid[i]);
            check("t6 pt ready", ready_o, pt_ready[i]);
            @(posedge clk);
            #1;
        end
        valid_i  = 1'b0;
        ready_i  = 1'b1;
        enable_i = 1'b1;
        @(posedge clk);
        #1;
        send(8'h99, 3'd6);
        rst_ni = 1'b0;
        #1;
        check("t6 rst valid_o", valid_o, 0);
        check("t6 rst data_o", data_o, 0);
        check("t6 rst retry", needs_retry_o, 0);
        check("t6 rst retry_id", retry_id_o, 0);
        check("t6 rst fault", fault_detected_o, 0);
        check("t6 rst ready_o", ready_o, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("t6 post-reset ready", ready_o, 1);

        check("data queue drained", exp_data_q.size(), 0);
        check("retry queue drained", exp_retry_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
